// File: rtl/layer_info_encoder.sv
// layer_info_encoder: packs layer descriptors into 32-bit layer_info words and writes a
// zero-terminated program into layer memory. Define LAYER_INFO_PARITY_EN for odd-parity bit 0.
module layer_info_encoder #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              start_in,
  input  logic              s_valid_in,
  output logic              s_ready_out,
  input  logic [3:0]        weight_height_in,
  input  logic [3:0]        weight_width_in,
  input  logic [7:0]        weight_start_addr_in,
  input  logic [3:0]        bias_height_in,
  input  logic [3:0]        bias_width_in,
  input  logic [7:0]        bias_start_addr_in,
  input  logic [2:0]        op_in,
  input  logic              last_in,
  output logic              wr_en_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [31:0]       wr_data_out,
  output logic [ADDR_W:0]   count_out,
  output logic              busy_out,
  output logic              done_out,
  output logic              err_out,
  output logic              full_out
);

  typedef enum logic [2:0] {StIdle, StRun, StWrite, StTerm, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, ptr_inc;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              err_q, err_d, full_q, full_d, last_q, last_d;
  logic [31:1]       layer_body;
  logic              layer_tag;
  logic              desc_legal;

  function automatic logic dim_ok(input logic [3:0] v);
    return (v != 4'd0) && (v <= 4'd8);
  endfunction

  function automatic logic [2:0] dim_enc(input logic [3:0] v);
    return 3'(v - 4'd1);
  endfunction

  assign layer_body = {dim_enc(weight_height_in), dim_enc(weight_width_in), weight_start_addr_in,
                       dim_enc(bias_height_in), dim_enc(bias_width_in), bias_start_addr_in,
                       op_in};

`ifdef LAYER_INFO_PARITY_EN
  assign layer_tag = ~^layer_body;
`else
  assign layer_tag = 1'b1;
`endif

  assign desc_legal = dim_ok(weight_height_in) && dim_ok(weight_width_in) &&
                      dim_ok(bias_height_in) && dim_ok(bias_width_in);

  assign ptr_inc = ptr_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    err_d     = err_q;
    full_d    = full_q;
    last_d    = last_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start_in) begin
          state_d = StRun;
          ptr_d   = '0;
          count_d = '0;
          err_d   = 1'b0;
          full_d  = 1'b0;
        end
      end
      StRun: begin
        if (s_valid_in) begin
          if (desc_legal) begin
            state_d   = StWrite;
            last_d    = last_in;
            wr_addr_d = ptr_q;
            wr_data_d = {layer_body, layer_tag};
          end else begin
            // Illegal descriptor is dropped; a last one still closes the program.
            err_d = 1'b1;
            if (last_in) begin
              state_d   = StTerm;
              wr_addr_d = ptr_q;
              wr_data_d = '0;
            end
          end
        end
      end
      StWrite: begin
        ptr_d   = ptr_inc;
        count_d = count_q + 1'b1;
        if (last_q) begin
          state_d   = StTerm;
          wr_addr_d = ptr_inc;
          wr_data_d = '0;
        end else if (ptr_inc == ADDR_W'(DEPTH - 1)) begin
          // Final slot is kept for the terminator.
          state_d   = StTerm;
          full_d    = 1'b1;
          wr_addr_d = ptr_inc;
          wr_data_d = '0;
        end else begin
          state_d = StRun;
        end
      end
      StTerm: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      full_q    <= 1'b0;
      last_q    <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      err_q     <= err_d;
      full_q    <= full_d;
      last_q    <= last_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign s_ready_out = (state_q == StRun);
  assign wr_en_out   = (state_q == StWrite) || (state_q == StTerm);
  assign wr_addr_out = wr_addr_q;
  assign wr_data_out = wr_data_q;
  assign count_out   = count_q;
  assign busy_out    = (state_q == StRun) || (state_q == StWrite) || (state_q == StTerm);
  assign done_out    = (state_q == StDone);
  assign err_out     = err_q;
  assign full_out    = full_q;

endmodule

// File: tb/tb_layer_info_encoder.sv
// Testbench for layer_info_encoder: a DEPTH=16 and a DEPTH=4 instance driven from shared
// descriptor inputs, checked against a program-level reference model.
module tb_layer_info_encoder;

  typedef struct {
    logic [3:0] wh;
    logic [3:0] ww;
    logic [7:0] wa;
    logic [3:0] bh;
    logic [3:0] bw;
    logic [7:0] ba;
    logic [2:0] op;
    logic       last;
  } desc_t;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic sel = 1'b0;
  logic s_valid = 1'b0;
  logic [3:0] wh = 4'd1, ww = 4'd1, bh = 4'd1, bw = 4'd1;
  logic [7:0] wa = 8'd0, ba = 8'd0;
  logic [2:0] op = 3'd0;
  logic last = 1'b0;

  logic start_a, start_b;
  logic rdy_a, wr_en_a, busy_a, done_a, err_a, full_a;
  logic rdy_b, wr_en_b, busy_b, done_b, err_b, full_b;
  logic [3:0] addr_a, addr_b;
  logic [31:0] data_a, data_b;
  logic [4:0] count_a, count_b;

  logic cur_rdy, cur_wr_en, cur_busy, cur_done, cur_err, cur_full;
  logic [3:0] cur_addr;
  logic [31:0] cur_data;
  logic [4:0] cur_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int done_cyc = 0;
  desc_t prog[$];
  wr_t got[$];
  wr_t exp[$];
  int exp_count;
  logic exp_err, exp_full;

  always #5 clk = ~clk;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  assign cur_rdy   = sel ? rdy_b : rdy_a;
  assign cur_wr_en = sel ? wr_en_b : wr_en_a;
  assign cur_busy  = sel ? busy_b : busy_a;
  assign cur_done  = sel ? done_b : done_a;
  assign cur_err   = sel ? err_b : err_a;
  assign cur_full  = sel ? full_b : full_a;
  assign cur_addr  = sel ? addr_b : addr_a;
  assign cur_data  = sel ? data_b : data_a;
  assign cur_count = sel ? count_b : count_a;

  layer_info_encoder #(.ADDR_W(4), .DEPTH(16)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start_a), .s_valid_in(s_valid),
    .s_ready_out(rdy_a), .weight_height_in(wh), .weight_width_in(ww),
    .weight_start_addr_in(wa), .bias_height_in(bh), .bias_width_in(bw),
    .bias_start_addr_in(ba), .op_in(op), .last_in(last), .wr_en_out(wr_en_a),
    .wr_addr_out(addr_a), .wr_data_out(data_a), .count_out(count_a), .busy_out(busy_a),
    .done_out(done_a), .err_out(err_a), .full_out(full_a)
  );

  layer_info_encoder #(.ADDR_W(4), .DEPTH(4)) dut_small (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start_b), .s_valid_in(s_valid),
    .s_ready_out(rdy_b), .weight_height_in(wh), .weight_width_in(ww),
    .weight_start_addr_in(wa), .bias_height_in(bh), .bias_width_in(bw),
    .bias_start_addr_in(ba), .op_in(op), .last_in(last), .wr_en_out(wr_en_b),
    .wr_addr_out(addr_b), .wr_data_out(data_b), .count_out(count_b), .busy_out(busy_b),
    .done_out(done_b), .err_out(err_b), .full_out(full_b)
  );

  function automatic desc_t mk(input int h, input int w, input int a, input int bhh,
                               input int bww, input int b, input int o, input bit l);
    desc_t d;
    d.wh = 4'(h); d.ww = 4'(w); d.wa = 8'(a);
    d.bh = 4'(bhh); d.bw = 4'(bww); d.ba = 8'(b);
    d.op = 3'(o); d.last = l;
    return d;
  endfunction

  function automatic bit legal(input desc_t d);
    return d.wh >= 1 && d.wh <= 8 && d.ww >= 1 && d.ww <= 8 &&
           d.bh >= 1 && d.bh <= 8 && d.bw >= 1 && d.bw <= 8;
  endfunction

  function automatic logic [31:0] enc(input desc_t d);
    logic [31:0] w;
    w = {3'(d.wh - 4'd1), 3'(d.ww - 4'd1), d.wa, 3'(d.bh - 4'd1), 3'(d.bw - 4'd1),
         d.ba, d.op, 1'b1};
`ifdef LAYER_INFO_PARITY_EN
    w[0] = ($countones(w[31:1]) % 2 == 0);
`endif
    return w;
  endfunction

  // Expected program: layer words in order, dropped illegal ones, terminator after them.
  task automatic model(input int depth);
    int p;
    p = 0;
    exp_err = 1'b0;
    exp_full = 1'b0;
    exp.delete();
    foreach (prog[i]) begin
      if (!legal(prog[i])) begin
        exp_err = 1'b1;
        if (prog[i].last) break;
        continue;
      end
      exp.push_back('{addr: p, data: enc(prog[i]), cyc: 0});
      p++;
      if (prog[i].last) break;
      if (p == depth - 1) begin
        exp_full = 1'b1;
        break;
      end
    end
    exp_count = p;
    exp.push_back('{addr: p, data: 32'h0, cyc: 0});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cur_wr_en) got.push_back('{addr: int'(cur_addr), data: cur_data, cyc: cyc});
  endtask

  task automatic drive(input desc_t d);
    wh = d.wh; ww = d.ww; wa = d.wa; bh = d.bh; bw = d.bw; ba = d.ba; op = d.op; last = d.last;
  endtask

  task automatic run_prog(input logic use_small, input bit noisy_start, input string name);
    bit acc;
    bit stop;
    int n;
    sel = use_small;
    got.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    stop = 0;
    foreach (prog[i]) begin
      drive(prog[i]);
      s_valid = 1'b1;
      if (i > 0) start = noisy_start;
      n = 0;
      forever begin
        if (!cur_busy) begin
          stop = 1;
          break;
        end
        acc = cur_rdy;
        step();
        if (acc) begin
          last_acc_cyc = cyc;
          break;
        end
        n++;
        if (n > 20) begin
          checks++; failures++;
          $display("FAIL %s handshake timeout: ready=%0b required 1", name, cur_rdy);
          stop = 1;
          break;
        end
      end
      start = 1'b0;
      if (stop) break;
    end
    start = 1'b0;
    s_valid = 1'b0;
    n = 0;
    while (!cur_done && n < 10) begin
      step();
      n++;
    end
    done_cyc = cyc;
    model(use_small ? 4 : 16);
    checks++;
    if (cur_done !== 1'b1) begin
      failures++;
      $display("FAIL %s done: got %0b required 1", name, cur_done);
    end
    checks++;
    if (got.size() != exp.size()) begin
      failures++;
      $display("FAIL %s write count: got %0d required %0d", name, got.size(), exp.size());
    end else begin
      foreach (exp[i]) begin
        if (got[i].addr != exp[i].addr || got[i].data !== exp[i].data) begin
          failures++;
          $display("FAIL %s write %0d: got @%0d=%h required @%0d=%h", name, i,
                   got[i].addr, got[i].data, exp[i].addr, exp[i].data);
          break;
        end
      end
    end
    checks++;
    if (int'(cur_count) != exp_count || cur_err !== exp_err || cur_full !== exp_full) begin
      failures++;
      $display("FAIL %s flags: got count=%0d err=%0b full=%0b required count=%0d err=%0b full=%0b",
               name, cur_count, cur_err, cur_full, exp_count, exp_err, exp_full);
    end
  endtask

  task automatic test_reset();
    logic [46:0] v;
    sel = 1'b0;
    v = {rdy_a, wr_en_a, addr_a, data_a, count_a, busy_a, done_a, err_a, full_a};
    checks++;
    if (v !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h required 0", v);
    end
  endtask

  task automatic test_single_layer();
    logic [31:0] lit;
    lit = {3'd2, 3'd3, 8'h10, 3'd2, 3'd0, 8'h40, 3'b101, 1'b1};
    prog.delete();
    prog.push_back(mk(3, 4, 'h10, 3, 1, 'h40, 5, 1));
    run_prog(1'b0, 1'b0, "single");
    checks++;
    if (got.size() < 2 || got[0].data[31:1] !== lit[31:1] || got[0].addr != 0) begin
      failures++;
      $display("FAIL single_word: got %h required %h", got.size() > 0 ? got[0].data : 32'hx,
               lit);
    end
    checks++;
`ifdef LAYER_INFO_PARITY_EN
    if (got.size() < 1 || ($countones(got[0].data) % 2) != 1) begin
      failures++;
      $display("FAIL single_parity: got %h required odd popcount", got[0].data);
    end
`else
    if (got.size() < 1 || got[0].data[0] !== 1'b1) begin
      failures++;
      $display("FAIL single_tag: got %h required bit0=1", got[0].data);
    end
`endif
    checks++;
    if (got.size() < 2 || got[0].cyc != last_acc_cyc || got[1].cyc != last_acc_cyc + 1 ||
        done_cyc != last_acc_cyc + 2) begin
      failures++;
      $display("FAIL single_timing: got accept=%0d writes=%0d,%0d done=%0d required %0d,%0d,%0d",
               last_acc_cyc, got.size() > 0 ? got[0].cyc : -1,
               got.size() > 1 ? got[1].cyc : -1, done_cyc,
               last_acc_cyc, last_acc_cyc + 1, last_acc_cyc + 2);
    end
  endtask

  task automatic test_back_to_back();
    prog.delete();
    prog.push_back(mk(1, 8, 'h00, 8, 1, 'h80, 0, 0));
    prog.push_back(mk(5, 2, 'h21, 4, 4, 'h99, 3, 0));
    prog.push_back(mk(8, 8, 'hff, 1, 8, 'h01, 7, 1));
    run_prog(1'b0, 1'b1, "b2b");
    checks++;
    if (got.size() != 4 || got[1].cyc != got[0].cyc + 2 || got[2].cyc != got[1].cyc + 2 ||
        got[3].cyc != got[2].cyc + 1) begin
      failures++;
      $display("FAIL b2b_spacing: got %0d writes, required 4 on alternate cycles", got.size());
    end
  endtask

  task automatic test_illegal();
    prog.delete();
    prog.push_back(mk(2, 2, 'h05, 2, 2, 'h06, 1, 0));
    prog.push_back(mk(2, 0, 'h07, 2, 2, 'h08, 2, 0));
    prog.push_back(mk(3, 3, 'h09, 9, 2, 'h0a, 4, 0));
    prog.push_back(mk(4, 4, 'h0b, 4, 4, 'h0c, 6, 1));
    run_prog(1'b0, 1'b0, "illegal");
  endtask

  task automatic test_full();
    prog.delete();
    for (int i = 0; i < 5; i++) prog.push_back(mk(i + 1, 2, i * 16, 3, i + 2, 255 - i, i, 0));
    run_prog(1'b1, 1'b0, "full");
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (cur_rdy !== 1'b0 || cur_full !== 1'b1) begin
        failures++;
        $display("FAIL full_hold: got ready=%0b full=%0b required 0,1", cur_rdy, cur_full);
      end
    end
    s_valid = 1'b0;
  endtask

  function automatic int rdim();
    if ($urandom_range(0, 11) == 0) return ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(9, 15);
    return $urandom_range(1, 8);
  endfunction

  task automatic test_random();
    int n;
    for (int t = 0; t < 10; t++) begin
      prog.delete();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++)
        prog.push_back(mk(rdim(), rdim(), $urandom_range(0, 255), rdim(), rdim(),
                          $urandom_range(0, 255), $urandom_range(0, 7), i == n - 1));
      run_prog(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_reset_mid();
    logic [46:0] v;
    sel = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    drive(mk(2, 3, 'h44, 5, 6, 'h55, 2, 0));
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    checks++;
    if (wr_en_a !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_write: got wr_en=%0b required 1", wr_en_a);
    end
    #2 rst_n = 1'b0;
    #1;
    v = {rdy_a, wr_en_a, addr_a, data_a, count_a, busy_a, done_a, err_a, full_a};
    checks++;
    if (v !== '0) begin
      failures++;
      $display("FAIL rst_mid_outputs: got %h required 0", v);
    end
    #2 rst_n = 1'b1;
    prog.delete();
    prog.push_back(mk(7, 1, 'hc3, 2, 8, 'h3c, 1, 1));
    run_prog(1'b0, 1'b0, "after_rst");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    #22 rst_n = 1'b1;
    #1;
    test_reset();
    step();
    test_single_layer();
    test_back_to_back();
    test_illegal();
    test_full();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/layer_info_encoder.md
# layer_info_encoder

Packs per-layer descriptors (matrix dimensions, start addresses, op bits) into 32-bit layer_info words and writes them sequentially into the layer program memory, then appends a terminator word. It sits between the host/UART command path and the layer program RAM that the sequencer reads and decodes. It is the writer side of the layer_info word format.

## Interface
Parameters:
- ADDR_W, 4: layer program memory address width.
- DEPTH, 16: program slots available (≤ 2**ADDR_W); the last usable slot is reserved for the terminator.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous, active-low reset
- start_in  input  1  one-cycle pulse; begins a new program at address 0
- s_valid_in  input  1  descriptor valid
- s_ready_out  output  1  encoder can accept a descriptor
- weight_height_in  input  4  rows, legal 1..8
- weight_width_in  input  4  cols, legal 1..8
- weight_start_addr_in  input  8  weight base address
- bias_height_in  input  4  legal 1..8
- bias_width_in  input  4  legal 1..8
- bias_start_addr_in  input  8  bias base address
- op_in  input  3  {reLU_sel, op_sel, flatten_sel}
- last_in  input  1  descriptor is the final layer
- wr_en_out  output  1  memory write strobe
- wr_addr_out  output  ADDR_W  memory write address
- wr_data_out  output  32  encoded word
- count_out  output  ADDR_W+1  layers written in current program
- busy_out  output  1  high in RUN/WRITE/TERM
- done_out  output  1  high in DONE
- err_out  output  1  sticky: illegal dimension seen
- full_out  output  1  sticky: program truncated by DEPTH

## Operation
- Word format: [31:29]=weight_height-1, [28:26]=weight_width-1, [25:18]=weight_start_addr, [17:15]=bias_height-1, [14:12]=bias_width-1, [11:4]=bias_start_addr, [3:1]=op, [0]=tag bit (see Configuration).
- Dimension fields encoded as (value-1)[2:0]; any dimension of 0 or >8 is illegal.
- Terminator word is 32'h0000_0000; a legal layer word is never zero.
- States:
  - IDLE: s_ready=0. start_in -> RUN, clears pointer, count, err, full.
  - RUN: s_ready=1. On s_valid&s_ready, register descriptor; legal -> WRITE; illegal -> set err, stay RUN (word dropped, pointer unchanged), unless last_in -> TERM.
  - WRITE: wr_en=1 at current pointer, s_ready=0; pointer and count +1. Next: if registered last -> TERM; else if new pointer == DEPTH-1 -> set full, TERM; else RUN.
  - TERM: wr_en=1, wr_data=0 at pointer; pointer not advanced; -> DONE.
  - DONE: holds outputs; start_in -> RUN (new program).
- start_in ignored in RUN/WRITE/TERM.
- Pointer never wraps; terminator always lands at address ≤ DEPTH-1.

## Timing
- Reset values: state IDLE, s_ready_out 0, wr_en_out 0, wr_addr_out 0, wr_data_out 0, count_out 0, busy_out 0, done_out 0, err_out 0, full_out 0.
- Handshake accepted in cycle N -> wr_en_out high in N+1 with word and address registered; s_ready_out low in N+1, high again in N+2 (if RUN).
- Throughput: one descriptor per 2 cycles.
- Accepted last descriptor in cycle N: layer write N+1, terminator write N+2, done_out high from N+3.
- All outputs registered; no combinational path input->output except none (s_ready_out is a state decode).
- Reset asserted mid-program: immediate return to IDLE, wr_en_out drops asynchronously; partial program in memory is not terminated.

## Configuration
- LAYER_INFO_PARITY_EN defined: bit[0] = odd-parity bit so the 32-bit word has odd parity (bit0 = ~^word[31:1]).
- Undefined: bit[0] = 1'b1 constant valid tag.
- Terminator is 32'h0 in both modes; all other behaviour identical.

## Test plan
- Single layer, last=1: 3x4 weights @0x10, 3x1 bias @0x40, op=3'b101, no parity -> addr0 = 32'h4C_4_1_0_4_0_B? precisely {3'd2,3'd3,8'h10,3'd2,3'd0,8'h40,3'b101,1'b1}, addr1 = 0, count=1, done=1.
- Same with LAYER_INFO_PARITY_EN -> bit0 set so popcount(word) is odd; terminator still 0.
- Three layers back-to-back with s_valid held high -> writes at addr 0,1,2 on alternate cycles, terminator at 3, count=3.
- Illegal width 0 on layer 2 of 3 -> err_out=1, only 2 layer words written (addr 0,1), terminator at 2.
- DEPTH=4, send 5 layers without last -> 3 layer writes, full_out=1, terminator at 3, done_out=1, s_ready_out stays 0.
- Assert rst_n_in low during WRITE -> wr_en_out 0 immediately, all outputs at reset values; subsequent start_in restarts at addr 0.
